// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_arbiter
// Purpose  : Two-port priority arbiter with B anti-starvation counter in front
//            of a single-port 16x4 synchronous-read data memory.
// Revision : 1.0  initial release
// ============================================================================
module dm_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [3:0] a_addr,
  input  logic [3:0] a_wdata,
  output logic       a_gnt,
  output logic       a_rvalid,
  output logic [3:0] a_rdata,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [3:0] b_addr,
  input  logic [3:0] b_wdata,
  output logic       b_gnt,
  output logic       b_rvalid,
  output logic [3:0] b_rdata,
  output logic [3:0] mem_addr,
  output logic [3:0] mem_wdata,
  output logic       mem_wren,
  input  logic [3:0] mem_rdata,
  output logic       owner
);

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  logic       w_a_win;
  logic       w_b_win;
  logic       w_rd_gnt;
  logic [3:0] r_wcnt;
  logic [3:0] r_addr_q;
  logic [3:0] r_wdata_q;
  logic       r_rd_pend;
  logic       r_rd_owner;
  logic       r_owner;

  // r_wcnt saturates at the limit, so equality is the "waited long enough" test
  always_comb begin
    w_a_win = 1'b0;
    w_b_win = 1'b0;
    if (reset) begin
      if (a_req && b_req) begin
        w_b_win = (r_wcnt == c_starve_limit);
        w_a_win = !w_b_win;
      end else begin
        w_a_win = a_req;
        w_b_win = b_req;
      end
    end
  end

  assign a_gnt = w_a_win;
  assign b_gnt = w_b_win;

  // Idle cycles keep the bus on the last winner's address and data
  always_comb begin
    mem_addr  = r_addr_q;
    mem_wdata = r_wdata_q;
    mem_wren  = 1'b0;
    if (!reset) begin
      mem_addr  = 4'd0;
      mem_wdata = 4'd0;
    end else if (w_a_win) begin
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
      mem_wren  = a_we;
    end else if (w_b_win) begin
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
      mem_wren  = b_we;
    end
  end

  assign w_rd_gnt = (w_a_win && !a_we) || (w_b_win && !b_we);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wcnt     <= 4'd0;
      r_addr_q   <= 4'd0;
      r_wdata_q  <= 4'd0;
      r_rd_pend  <= 1'b0;
      r_rd_owner <= 1'b0;
      r_owner    <= 1'b0;
    end else begin
      if (w_a_win || w_b_win) begin
        r_addr_q  <= mem_addr;
        r_wdata_q <= mem_wdata;
        r_owner   <= w_b_win;
      end
      r_rd_pend  <= w_rd_gnt;
      r_rd_owner <= w_b_win;
      if (b_req && !w_b_win) begin
        if (r_wcnt != c_starve_limit) begin
          r_wcnt <= r_wcnt + 4'd1;
        end
      end else begin
        r_wcnt <= 4'd0;
      end
    end
  end

  // Gating with reset drops a read whose data would return during reset
  assign a_rvalid = reset && r_rd_pend && !r_rd_owner;
  assign b_rvalid = reset && r_rd_pend && r_rd_owner;
  assign a_rdata  = mem_rdata;
  assign b_rdata  = mem_rdata;
  assign owner    = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_arbiter
// Purpose  : Scoreboard bench for dm_arbiter with a behavioural arbitration
//            and memory model; second instance covers STARVE_LIMIT = 0.
// Revision : 1.0  initial release
// ============================================================================
module tb_dm_arbiter;

  localparam int LIM = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [3:0] a_addr = 4'd0, a_wdata = 4'd0, b_addr = 4'd0, b_wdata = 4'd0;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid, mem_wren, owner;
  logic [3:0] a_rdata, b_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_rdata = 4'd0;
  logic [3:0] ram [16];

  logic       z_reset = 1'b0, z_areq = 1'b0, z_breq = 1'b0;
  logic       z_agnt, z_bgnt, z_arv, z_brv, z_wren, z_owner;
  logic [3:0] z_ard, z_brd, z_addr, z_wd;

  always #5 clk = ~clk;

  dm_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  dm_arbiter #(.STARVE_LIMIT(0)) dut0 (
    .clk(clk), .reset(z_reset),
    .a_req(z_areq), .a_we(1'b0), .a_addr(4'd1), .a_wdata(4'd0),
    .a_gnt(z_agnt), .a_rvalid(z_arv), .a_rdata(z_ard),
    .b_req(z_breq), .b_we(1'b0), .b_addr(4'd2), .b_wdata(4'd0),
    .b_gnt(z_bgnt), .b_rvalid(z_brv), .b_rdata(z_brd),
    .mem_addr(z_addr), .mem_wdata(z_wd), .mem_wren(z_wren),
    .mem_rdata(4'd0), .owner(z_owner)
  );

  // Single-port synchronous RAM standing in for data_memory
  initial for (int i = 0; i < 16; i++) ram[i] = 4'd0;
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       ag, bg, wren, own;
    logic [3:0] addr, wd;
  } gexp_t;
  typedef struct {
    int         cyc;
    logic       port;
    logic [3:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;
  bit cnt_en = 1'b0;
  int b_cnt = 0;

  // Reference model state
  int         m_refused = 0;
  logic       m_owner = 1'b0;
  logic [3:0] m_laddr = 4'd0, m_lwd = 4'd0;
  logic [3:0] shadow [16];
  initial for (int i = 0; i < 16; i++) shadow[i] = 4'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // One cycle of stimulus; the model derives the expected response from the rules
  task automatic step(input logic rn,
                      input logic ar, input logic awe, input logic [3:0] aad, input logic [3:0] awd,
                      input logic br, input logic bwe, input logic [3:0] bad, input logic [3:0] bwd,
                      output logic aw, output logic bw);
    gexp_t e;
    rexp_t r;
    logic  we_w;
    logic [3:0] ad_w, wd_w;
    @(posedge clk);
    #1;
    started = 1'b1;
    reset = rn;
    a_req = ar; a_we = awe; a_addr = aad; a_wdata = awd;
    b_req = br; b_we = bwe; b_addr = bad; b_wdata = bwd;
    aw = 1'b0; bw = 1'b0;
    e.own = m_owner;
    if (!rn) begin
      e.ag = 1'b0; e.bg = 1'b0; e.wren = 1'b0; e.addr = 4'd0; e.wd = 4'd0;
      if (rq.size() > 0 && rq[rq.size()-1].cyc == cyc) rq.delete(rq.size()-1);
      m_owner = 1'b0; m_refused = 0; m_laddr = 4'd0; m_lwd = 4'd0;
    end else begin
      aw = ar && !(br && m_refused >= LIM);
      bw = br && !aw;
      e.ag = aw; e.bg = bw;
      we_w = aw ? awe : bwe;
      ad_w = aw ? aad : bad;
      wd_w = aw ? awd : bwd;
      if (aw || bw) begin
        e.addr = ad_w; e.wd = wd_w; e.wren = we_w;
        if (!we_w) begin
          r.cyc = cyc + 1; r.port = bw; r.data = shadow[ad_w];
          rq.push_back(r);
        end else begin
          shadow[ad_w] = wd_w;
        end
        m_laddr = ad_w; m_lwd = wd_w; m_owner = bw;
      end else begin
        e.addr = m_laddr; e.wd = m_lwd; e.wren = 1'b0;
      end
      if (br && !bw) m_refused = (m_refused + 1 > LIM) ? LIM : m_refused + 1;
      else m_refused = 0;
    end
    gq.push_back(e);
  endtask

  // Monitor: pops expectations as the DUT presents grants and read data
  always @(negedge clk) begin
    gexp_t e;
    rexp_t r;
    logic  exp_v;
    if (started) begin
      if (gq.size() > 0) begin
        e = gq.pop_front();
        chk("a_gnt", a_gnt, e.ag);
        chk("b_gnt", b_gnt, e.bg);
        chk("mem_wren", mem_wren, e.wren);
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_wdata", mem_wdata, e.wd);
        chk("owner", owner, e.own);
      end
      exp_v = (rq.size() > 0) && (rq[0].cyc == cyc);
      if (exp_v) begin
        r = rq.pop_front();
        chk("a_rvalid", a_rvalid, !r.port);
        chk("b_rvalid", b_rvalid, r.port);
        if (!r.port) chk("a_rdata", a_rdata, r.data);
        else         chk("b_rdata", b_rdata, r.data);
      end else if (a_rvalid || b_rvalid) begin
        chk("rvalid_spurious", {a_rvalid, b_rvalid}, 2'b00);
      end
      if (cnt_en && b_gnt) b_cnt++;
    end
  end

  logic aw, bw;
  logic ap = 1'b0, bp = 1'b0;
  logic rn, ar, awe, br, bwe;
  logic [3:0] aad, awd, bad, bwd;

  initial begin
    repeat (3) step(0, 0,0,0,0, 0,0,0,0, aw, bw);
    // A alone: write 0xA to 5, read it back
    step(1, 1,1,4'd5,4'hA, 0,0,0,0, aw, bw);
    step(1, 1,0,4'd5,4'h0, 0,0,0,0, aw, bw);
    step(1, 0,0,0,0, 0,0,0,0, aw, bw);
    // Continuous reads from both ports: A,A,A,A,B pattern
    cnt_en = 1'b1;
    for (int i = 0; i < 20; i++) step(1, 1,0,4'(i),0, 1,0,4'd9,0, aw, bw);
    step(1, 0,0,0,0, 0,0,0,0, aw, bw);
    cnt_en = 1'b0;
    chk("b_grants_in_20", b_cnt, 4);
    // Same-address write by A and read by B in the same cycle
    step(1, 1,1,4'd3,4'h7, 1,0,4'd3,0, aw, bw);
    step(1, 0,0,0,0,       1,0,4'd3,0, aw, bw);
    step(1, 0,0,0,0, 0,0,0,0, aw, bw);
    // B withdraws after 3 refusals, then must wait 4 again
    for (int i = 0; i < 3; i++) step(1, 1,0,4'd5,0, 1,0,4'd3,0, aw, bw);
    step(1, 1,0,4'd5,0, 0,0,0,0, aw, bw);
    for (int i = 0; i < 5; i++) step(1, 1,0,4'd5,0, 1,0,4'd3,0, aw, bw);
    step(1, 0,0,0,0, 0,0,0,0, aw, bw);
    // B read then reset while its data returns: owner 1 -> 0, rvalid dropped
    step(1, 0,0,0,0, 1,0,4'd3,0, aw, bw);
    step(0, 1,0,4'd5,0, 0,0,0,0, aw, bw);
    // A read, reset in the following cycle, then immediate A grant
    step(1, 1,0,4'd5,0, 0,0,0,0, aw, bw);
    step(0, 1,0,4'd5,0, 0,0,0,0, aw, bw);
    step(1, 1,0,4'd5,0, 0,0,0,0, aw, bw);
    step(1, 0,0,0,0, 0,0,0,0, aw, bw);
    // Randomized traffic honouring the hold-while-waiting protocol
    for (int i = 0; i < 3000; i++) begin
      rn = ($urandom_range(0, 299) != 0);
      if (!ap) begin
        ar = ($urandom_range(0, 9) < 6); awe = 1'($urandom);
        aad = 4'($urandom); awd = 4'($urandom);
      end else ar = ($urandom_range(0, 7) != 0);
      if (!bp) begin
        br = ($urandom_range(0, 9) < 5); bwe = 1'($urandom);
        bad = 4'($urandom); bwd = 4'($urandom);
      end else br = ($urandom_range(0, 7) != 0);
      step(rn, ar, awe, aad, awd, br, bwe, bad, bwd, aw, bw);
      ap = rn && ar && !aw;
      bp = rn && br && !bw;
    end
    repeat (3) step(1, 0,0,0,0, 0,0,0,0, aw, bw);
    @(negedge clk);
    #1;
    chk("reads_outstanding", rq.size(), 0);

    // STARVE_LIMIT = 0: B wins every tie, A wins once B drops
    @(posedge clk); #1;
    z_reset = 1'b1; z_areq = 1'b1; z_breq = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("lim0_b_gnt", z_bgnt, 1'b1);
      chk("lim0_a_gnt", z_agnt, 1'b0);
      @(posedge clk); #1;
    end
    z_breq = 1'b0;
    @(negedge clk);
    chk("lim0_a_after_b_drop", z_agnt, 1'b1);
    chk("lim0_b_after_drop", z_bgnt, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter that shares the single-port 16x4 data memory between the processor core (port A) and a host/debug access port (port B). Each cycle it grants at most one requester, drives the memory address, write-data and write-enable lines from the winner, and returns read data to the winner one cycle later. Port A has priority. Port B is protected from starvation by a bounded wait counter. The block sits between the computational unit's data-memory lines and the data_memory RAM instance.

## Interface
Parameters:
- STARVE_LIMIT, default 4: number of consecutive cycles port B may be refused while requesting before it wins a tie. Legal range is 0..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset
- a_req  in  1  port A access request
- a_we  in  1  port A write (1) / read (0)
- a_addr  in  4  port A word address
- a_wdata  in  4  port A write data
- a_gnt  out  1  port A access performed this cycle
- a_rvalid  out  1  port A read data valid
- a_rdata  out  4  port A read data
- b_req, b_we, b_addr[3:0], b_wdata[3:0], b_gnt, b_rvalid, b_rdata[3:0]: port B signals, same meanings as the port A signals
- mem_addr  out  4  memory address
- mem_wdata  out  4  memory write data
- mem_wren  out  1  memory write enable
- mem_rdata  in  4  memory read data; valid the cycle after the address is presented
- owner  out  1  registered: 0 = last grant went to A, 1 = last grant went to B

## Operation
- Grant decision is combinational from the request inputs and the registered wait counter wcnt (4 bits):
  - only a_req asserted: A wins
  - only b_req asserted: B wins
  - both asserted: B wins if wcnt >= STARVE_LIMIT, otherwise A wins
  - neither asserted: no grant; mem_wren = 0; mem_addr and mem_wdata hold their last driven values
- Winner's x_gnt = 1 in the decision cycle. mem_addr, mem_wdata and mem_wren are driven from the winner's address, write data and write flag in that same cycle. Exactly one gnt is high at most.
- wcnt update at the clock edge:
  - b_req && !b_gnt: increment, saturating at STARVE_LIMIT
  - b_gnt or !b_req: clear to 0
- Read grant (x_we = 0): a pending-read flag and its owner are registered. Next cycle, that port's x_rvalid = 1 and x_rdata = mem_rdata. The other port's rvalid = 0.
- Write grant: no rvalid is produced. The written value is visible to any read granted in a later cycle.
- Requester protocol:
  - address, we and wdata stay stable while req is high and gnt is low
  - keeping req high after a gnt requests a new access; one access is performed per gnt cycle
  - dropping req before gnt is allowed; the request is withdrawn
- x_rdata outside an rvalid cycle is don't-care; the bench must not check it.
- STARVE_LIMIT = 0: B wins every tie.

## Timing
- Reset (reset = 0 at an edge):
  - wcnt = 0, pending-read flag = 0, owner = 0, a_rvalid = b_rvalid = 0
  - while reset is low: a_gnt = b_gnt = 0, mem_wren = 0, mem_addr = 0, mem_wdata = 0
- Grant latency: 0 cycles (same cycle as req) when the port wins.
- Read latency: rvalid exactly 1 cycle after the read gnt. Back-to-back reads give one rvalid per cycle.
- Worst-case B wait under continuous A traffic: STARVE_LIMIT refused cycles, then a grant on the next cycle.
- Reset asserted in the cycle after a read grant: rvalid is suppressed and that read data is discarded.
- Read and write to the same address by A and B in the same cycle are serialized by the grant. The loser sees the winner's result.

## Test plan
- A alone writes 0xA to addr 5, then reads addr 5:
  - a_gnt is high in both request cycles
  - a_rvalid = 1 with a_rdata = 0xA one cycle after the read gnt
  - b_gnt stays 0 throughout
- A and B both request reads continuously, STARVE_LIMIT = 4: grant sequence is A,A,A,A,B repeating. Each B grant clears wcnt to 0.
- STARVE_LIMIT = 0 with both requesting continuously: B is granted every cycle and A never is. A is granted in the first cycle after b_req drops.
- Same cycle: A writes 0x7 to addr 3 and B reads addr 3. A holds its request for one cycle only.
  - cycle 1: A is granted
  - cycle 2: B is granted
  - cycle 3: b_rvalid = 1 with b_rdata = 0x7
- B request withdrawn: B requests for 3 refused cycles (wcnt = 3), then drops b_req for 1 cycle. wcnt must return to 0, and B must then wait a full 4 refused cycles again.
- Reset: reset is driven low in the cycle following an A read gnt.
  - next cycle: a_rvalid = 0
  - owner = 0, wcnt = 0, mem_wren = 0
  - after release, the first A request is granted immediately
